modred_iter_ctrl: RTL and testbench

- Iterative word-level Montgomery reduction engine with a single W_SIZE-bit reduction stage (one qH multiplier) that is reused ITER times under FSM control.
- Used instead of an unrolled chain of stages where area matters, e.g. shared after the NTT butterfly multiplier.
- Accepts a double-width product T over a valid/ready handshake and returns C = T·2^(-W_SIZE·ITER) mod q, where q = qH·2^W_SIZE + 1.

---
 rtl/modred_pkg.sv | 31 +++
 rtl/modred_step_dp.sv | 73 +++++++
 rtl/modred_iter_ctrl.sv | 138 +++++++++++++
 tb/tb_modred_iter_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/modred_pkg.sv
// Shared definitions for the iterative Montgomery reduction engine.
//
// Contents:
//   state_t / ST_*  : FSM state encoding (3 bits). It is a plain logic
//                     vector so that older tools and waveform scripts can
//                     read the state as a number.
//   clog2()         : ceiling log2, used for the iteration counter width.
//   calc_iter()     : number of W_SIZE-bit reduction iterations needed to
//                     cover a DATA_SIZE_ARB-bit modulus.
package modred_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_MUL   = 3'd1;
  localparam state_t ST_ACC   = 3'd2;
  localparam state_t ST_FINAL = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int calc_iter(input int data_size, input int w_size);
    return (data_size + w_size - 1) / w_size;
  endfunction

endpackage

// File: rtl/modred_step_dp.sv
// One word-level Montgomery reduction step, split over two cycles.
//
// Stage 1 (mul_en high): the step's three terms are computed from the
// current accumulator and registered.
//   mult_q  = qh_r * t2, where t2 = -acc[W_SIZE-1:0] mod 2^W_SIZE
//   shift_q = acc >> W_SIZE
//   carry_q = 1 when the low word of acc is non-zero
// Stage 2 is purely combinational: acc_next = shift_q + mult_q + carry_q.
// The owner of the accumulator loads acc_next when it wants the step to
// take effect.
//
// This equals (acc + q*t2) / 2^W_SIZE with q = qh*2^W_SIZE + 1. The low
// word of acc + t2 is always zero, so that sum is either 0 or 2^W_SIZE,
// and its overflow into the upper bits is exactly carry_q.
//
// Ports:
//   clk, reset : clock and asynchronous active-low reset
//   mul_en     : load enable for the stage 1 registers
//   acc        : current accumulator (2*DATA_SIZE_ARB bits)
//   qh_r       : registered upper part of the modulus
//   acc_next   : accumulator after this reduction step
module modred_step_dp
  import modred_pkg::*;
#(
  parameter int DATA_SIZE_ARB = 32,
  parameter int W_SIZE        = 11
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            mul_en,
  input  logic [2*DATA_SIZE_ARB-1:0]      acc,
  input  logic [DATA_SIZE_ARB-W_SIZE-1:0] qh_r,
  output logic [2*DATA_SIZE_ARB-1:0]      acc_next
);

  localparam int D  = DATA_SIZE_ARB;
  localparam int QW = DATA_SIZE_ARB - W_SIZE;

  logic [W_SIZE-1:0] acc_lo;
  logic [W_SIZE-1:0] t2;
  logic [D-1:0]      qh_ext;
  logic [D-1:0]      t2_ext;
  logic [D-1:0]      mult_q;
  logic [2*D-1:0]    shift_q;
  logic              carry_q;

  // t2 is the multiple of q that clears the accumulator's low word. Both
  // multiplier operands are widened to D bits; qh*t2 always fits in D bits.
  always_comb begin
    acc_lo = acc[W_SIZE-1:0];
    t2     = '0 - acc_lo;
    qh_ext = {{W_SIZE{1'b0}}, qh_r};
    t2_ext = {{QW{1'b0}}, t2};
  end

  // A non-zero low word, or its negation, always has the top bit set, so
  // OR-ing those two top bits gives the carry without a wide compare.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mult_q  <= '0;
      shift_q <= '0;
      carry_q <= 1'b0;
    end else if (mul_en) begin
      mult_q  <= qh_ext * t2_ext;
      shift_q <= {{W_SIZE{1'b0}}, acc[2*D-1:W_SIZE]};
      carry_q <= acc_lo[W_SIZE-1] | t2[W_SIZE-1];
    end
  end

  // The sum is formed at full accumulator width so nothing is lost.
  assign acc_next = shift_q + {{D{1'b0}}, mult_q} + {{(2*D-1){1'b0}}, carry_q};

endmodule

// File: rtl/modred_iter_ctrl.sv
// Iterative Montgomery reduction engine. A single W_SIZE-bit reduction
// step (modred_step_dp) is reused ITER times. The result is
// C = T * 2^(-W_SIZE*ITER) mod q, where q = qH*2^W_SIZE + 1.
//
// The caller guarantees T < q*2^(W_SIZE*ITER). Under that condition the
// accumulator is below 2q after the last step, so a single conditional
// subtraction fully reduces it.
//
// Build option MODRED_LAZY_EN:
//   defined   - The FINAL state is skipped. C is taken straight from the
//               last step and is only guaranteed to be in [0, 2q).
//               Latency is 2*ITER.
//   undefined - C is fully reduced into [0, q). Latency is 2*ITER+1.
//
// Ports:
//   clk, reset          : clock and asynchronous active-low reset
//   qH                  : upper part of the modulus, sampled on accept
//   in_valid, in_ready  : input handshake for T
//   T                   : double-width product to reduce
//   out_valid, out_ready: output handshake for C
//   C                   : reduced result
//   busy                : high whenever the engine is not idle
module modred_iter_ctrl
  import modred_pkg::*;
#(
  parameter int DATA_SIZE_ARB = 32,
  parameter int W_SIZE        = 11
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_SIZE_ARB-W_SIZE-1:0] qH,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [2*DATA_SIZE_ARB-1:0]      T,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_SIZE_ARB-1:0]        C,
  output logic                            busy
);

  localparam int D     = DATA_SIZE_ARB;
  localparam int QW    = DATA_SIZE_ARB - W_SIZE;
  localparam int ITER  = calc_iter(DATA_SIZE_ARB, W_SIZE);
  localparam int CNT_W = clog2(ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_t            state;
  logic [2*D-1:0]    acc;
  logic [2*D-1:0]    acc_next;
  logic [QW-1:0]     qh_r;
  logic [CNT_W-1:0]  cnt;
  logic              mul_en;

`ifndef MODRED_LAZY_EN
  logic [D-1:0]      q_r;

  assign q_r = {qh_r, {W_SIZE{1'b0}}} + {{(D-1){1'b0}}, 1'b1};
`endif

  // in_ready is also held low while reset is asserted, so it only rises
  // once the engine has been released.
  assign in_ready = (state == ST_IDLE) && reset;
  assign busy     = (state != ST_IDLE);
  assign mul_en   = (state == ST_MUL);

  modred_step_dp #(
    .DATA_SIZE_ARB (DATA_SIZE_ARB),
    .W_SIZE        (W_SIZE)
  ) u_step (
    .clk      (clk),
    .reset    (reset),
    .mul_en   (mul_en),
    .acc      (acc),
    .qh_r     (qh_r),
    .acc_next (acc_next)
  );

  // The FSM alternates MUL/ACC once per iteration, then hands the
  // accumulator to FINAL (or straight to C in lazy mode). C and out_valid
  // hold in DONE until the consumer takes the result. in_ready is low in
  // DONE, so a new operand is never accepted in the same cycle as output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      acc       <= '0;
      qh_r      <= '0;
      cnt       <= '0;
      C         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            acc   <= T;
            qh_r  <= qH;
            cnt   <= '0;
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          state <= ST_ACC;
        end
        ST_ACC: begin
          acc <= acc_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
`ifdef MODRED_LAZY_EN
            C         <= acc_next[D-1:0];
            out_valid <= 1'b1;
            state     <= ST_DONE;
`else
            state     <= ST_FINAL;
`endif
          end else begin
            state <= ST_MUL;
          end
        end
`ifndef MODRED_LAZY_EN
        ST_FINAL: begin
          C         <= (acc >= {{D{1'b0}}, q_r}) ? (acc[D-1:0] - q_r) : acc[D-1:0];
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modred_iter_ctrl.sv
// Testbench for modred_iter_ctrl.
//
// Expected results come from modular arithmetic in the bench itself. T is
// reduced mod q, then halved mod q once per bit, W_SIZE*ITER times in all.
// Directed cases cover the zero, unit and exact-multiple operands, a
// large operand, back-pressure, and reset in the middle of an operation.
// These are followed by a randomized regression with random idle gaps,
// output stalls and in_valid noise while the engine is busy.
// Define MODRED_LAZY_EN to build and check the lazy-reduction variant.
module tb_modred_iter_ctrl;

  localparam int DATA_SIZE_ARB = 32;
  localparam int W_SIZE        = 11;
  localparam int ITER          = 3;
  localparam int SHIFT_BITS    = W_SIZE * ITER;
`ifdef MODRED_LAZY_EN
  localparam int LATENCY = 2 * ITER;
  localparam int QH_MAX  = (1 << 20) - 1;
`else
  localparam int LATENCY = 2 * ITER + 1;
  localparam int QH_MAX  = (1 << 21) - 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [20:0] qH = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] T = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] C;
  logic        busy;

  int check_count = 0;
  int error_count = 0;

  always #5 clk = ~clk;

  modred_iter_ctrl #(
    .DATA_SIZE_ARB (DATA_SIZE_ARB),
    .W_SIZE        (W_SIZE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .qH        (qH),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .T         (T),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic longint unsigned modulusOf(input logic [20:0] qh);
    longint unsigned q;
    q = 64'(qh);
    return (q << W_SIZE) + 64'd1;
  endfunction

  // Computes T * 2^-SHIFT_BITS mod q by repeated modular halving.
  function automatic longint unsigned refMont(input logic [20:0] qh,
                                              input logic [63:0] t);
    longint unsigned q;
    longint unsigned x;
    q = modulusOf(qh);
    x = t % q;
    for (int i = 0; i < SHIFT_BITS; i++)
      x = x[0] ? ((x + q) >> 1) : (x >> 1);
    return x;
  endfunction

  task automatic checkResult(input string tag, input logic [20:0] qh,
                             input longint unsigned expected);
    longint unsigned q;
    q = modulusOf(qh);
`ifdef MODRED_LAZY_EN
    checkOutput({tag, "_cong"}, 64'(C) % q, expected);
    checkOutput({tag, "_range"}, 64'(64'(C) < 2 * q), 64'd1);
`else
    checkOutput({tag, "_c"}, 64'(C), expected);
    checkOutput({tag, "_range"}, 64'(64'(C) < q), 64'd1);
`endif
  endtask

  // Runs one complete transaction: an idle gap, the accept, a bounded wait
  // for out_valid, an optional output stall, then the return to IDLE.
  task automatic applyStimulus(input logic [20:0] qh, input logic [63:0] t,
                               input int gap, input int hold_off, input bit noisy,
                               input longint unsigned expected, input string tag);
    int          k;
    bit          saw_ready;
    bit          stable;
    logic [31:0] c_seen;
    out_ready = (hold_off == 0);
    repeat (gap) @(negedge clk);
    checkOutput({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    qH       = qh;
    T        = t;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput({tag, "_busy"}, 64'(busy), 64'd1);
    saw_ready = in_ready;
    k = 0;
    while (!out_valid && k < 4 * LATENCY) begin
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        T        = {$urandom, $urandom};
        qH       = 21'($urandom);
      end
      @(negedge clk);
      k++;
      saw_ready |= in_ready;
    end
    in_valid = 1'b0;
    checkOutput({tag, "_latency"}, 64'(k), 64'(LATENCY));
    checkOutput({tag, "_ready_low"}, 64'(saw_ready), 64'd0);
    checkResult(tag, qh, expected);
    c_seen = C;
    stable = 1'b1;
    for (int h = 0; h < hold_off; h++) begin
      if (noisy) in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      stable &= out_valid && (C == c_seen) && !in_ready;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    if (hold_off > 0) checkOutput({tag, "_hold"}, 64'(stable), 64'd1);
    checkOutput({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_idle"}, 64'(busy), 64'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [20:0]     qh;
    logic [63:0]     t;
    longint unsigned q;
    bit              leak;

    repeat (3) @(negedge clk);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_c", 64'(C), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    applyStimulus(21'd6, 64'd0, 0, 0, 1'b0, 64'd0, "zero");
    applyStimulus(21'd6, 64'd1 << 33, 1, 0, 1'b0, 64'd1, "one");
    applyStimulus(21'd6, 64'd5 << 33, 0, 1, 1'b0, 64'd5, "five");
    applyStimulus(21'd6, 64'd12289 * 64'd7, 2, 0, 1'b0, 64'd0, "mult_q");
    applyStimulus(21'd6, 64'd12288 * 64'd12288, 0, 0, 1'b0,
                  refMont(21'd6, 64'd12288 * 64'd12288), "big");
    applyStimulus(21'd6, 64'd12345678901, 1, 10, 1'b1,
                  refMont(21'd6, 64'd12345678901), "backpressure");
    applyStimulus(21'd6, 64'd5 << 33, 0, 0, 1'b0, 64'd5, "pre_reset");

    // Reset in the middle of an operation must abort it without output.
    @(negedge clk);
    in_valid = 1'b1;
    qH       = 21'd6;
    T        = 64'd1 << 33;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_c", 64'(C), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    leak = 1'b0;
    repeat (12) begin
      @(negedge clk);
      leak |= out_valid || busy;
    end
    checkOutput("abort_no_output", 64'(leak), 64'd0);
    applyStimulus(21'd6, 64'd1 << 33, 0, 0, 1'b0, 64'd1, "post_reset");

    for (int n = 0; n < 1200; n++) begin
      qh = 21'($urandom_range(1, QH_MAX));
      q  = modulusOf(qh);
      if ($urandom_range(0, 7) == 0)
        t = (q < (64'd1 << 31)) ? ((q << SHIFT_BITS) - 64'd1) : '1;
      else begin
        t = {$urandom, $urandom};
        if (q < (64'd1 << 31)) t = t % (q << SHIFT_BITS);
      end
      applyStimulus(qh, t, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'b1, refMont(qh, t), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
